encoder_gate_ctrl: RTL

Gate-window sequencer for a quadrature-less incremental encoder (single `ticks` line) on the 50 MHz `CLK` domain. It synchronizes the raw tick input and schedules fixed-length measurement windows. For each window it counts rising edges, then converts the count to an 11-bit RPM value with saturation and publishes it with a one-cycle valid strobe. It sits between the encoder pin and the motor-speed consumers, and replaces free-running tick counting with a controlled, enable-gated measurement schedule plus stall detection.

---
 rtl/encoder_gate_ctrl.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/encoder_gate_ctrl.sv
// encoder_gate_ctrl: gated tick counter for a single-line incremental encoder.
// The raw tick line passes through a 2-flop synchronizer. Rising edges are
// counted over back-to-back windows of GATE_CYCLES cycles. Each window count
// is scaled to RPM, saturated to 11 bits and published with a 1-cycle strobe.
// The block also flags a stall when no edge arrives for STALL_CYCLES cycles.
module encoder_gate_ctrl #(
  parameter int unsigned GATE_CYCLES  = 3_000_000,
  parameter int unsigned RPM_PER_EDGE = 1,
  parameter int unsigned EDGE_W       = 16,
  parameter int unsigned STALL_CYCLES = 6_000_000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        enable,
  input  logic        ticks,
  output logic [10:0] rpm,
  output logic        rpm_valid,
  output logic        overflow,
  output logic        stalled
);

  localparam int GATE_W  = $clog2(GATE_CYCLES);
  localparam int STALL_W = $clog2(STALL_CYCLES + 1);
  localparam int MUL_W   = $clog2(RPM_PER_EDGE + 1);
  localparam int PROD_W  = EDGE_W + MUL_W;
  // Give the product at least 11 bits so the rpm slice is always legal.
  localparam int EXT_W   = (PROD_W > 11) ? PROD_W : 11;

  localparam logic [GATE_W-1:0]  GATE_LAST = GATE_W'(GATE_CYCLES - 1);
  localparam logic [EDGE_W-1:0]  EDGE_MAX  = '1;
  localparam logic [STALL_W-1:0] STALL_LIM = STALL_W'(STALL_CYCLES);
  localparam logic [EXT_W-1:0]   RPM_SAT   = EXT_W'(2047);
  localparam logic [EXT_W-1:0]   SCALE     = EXT_W'(RPM_PER_EDGE);

  typedef enum logic [1:0] {S_IDLE, S_PRIME, S_COUNT} state_t;

  state_t             r_state;
  logic               r_prime;
  logic [GATE_W-1:0]  r_gate;
  logic [EDGE_W-1:0]  r_edge;
  logic [STALL_W-1:0] r_stall;
  logic               r_s1, r_s2, r_s2_d;

  logic               w_rise;
  logic [EDGE_W-1:0]  w_edge_next;
  logic [EXT_W-1:0]   w_prod;
  logic               w_ovf;
  logic [STALL_W-1:0] w_stall_inc;

  assign w_rise      = r_s2 & ~r_s2_d;
  // The edge count includes an edge detected in the current cycle. This
  // matters on the last gate cycle, where the count is published directly.
  assign w_edge_next = (w_rise && (r_edge != EDGE_MAX)) ? r_edge + 1'b1 : r_edge;
  assign w_prod      = EXT_W'(w_edge_next) * SCALE;
  assign w_ovf       = (w_prod > RPM_SAT);
  assign w_stall_inc = (r_stall == STALL_LIM) ? r_stall : r_stall + 1'b1;

  // Two-flop synchronizer plus a delayed copy for rising-edge detection.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_s1   <= 1'b0;
      r_s2   <= 1'b0;
      r_s2_d <= 1'b0;
    end else begin
      r_s1   <= ticks;
      r_s2   <= r_s1;
      r_s2_d <= r_s2;
    end
  end

  // Window sequencer: idle / prime the synchronizer / count, plus publish and stall.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state   <= S_IDLE;
      r_prime   <= 1'b0;
      r_gate    <= '0;
      r_edge    <= '0;
      r_stall   <= '0;
      rpm       <= '0;
      rpm_valid <= 1'b0;
      overflow  <= 1'b0;
      stalled   <= 1'b0;
    end else begin
      rpm_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_gate  <= '0;
          r_edge  <= '0;
          r_stall <= '0;
          r_prime <= 1'b0;
          stalled <= 1'b0;
          if (enable) r_state <= S_PRIME;
        end
        S_PRIME: begin
          // Two cycles so stale synchronizer contents never count as an edge.
          if (!enable) begin
            r_state <= S_IDLE;
            r_prime <= 1'b0;
          end else if (r_prime) begin
            r_state <= S_COUNT;
            r_prime <= 1'b0;
          end else begin
            r_prime <= 1'b1;
          end
        end
        S_COUNT: begin
          if (r_gate == GATE_LAST) begin
            rpm       <= w_ovf ? 11'd2047 : w_prod[10:0];
            overflow  <= w_ovf;
            rpm_valid <= 1'b1;
            r_gate    <= '0;
            r_edge    <= '0;
          end else begin
            r_gate <= r_gate + 1'b1;
            r_edge <= w_edge_next;
          end
          // r_stall holds the number of COUNT cycles since the last detect,
          // so the cycle after a detect reads 1.
          if (w_rise) begin
            r_stall <= STALL_W'(1);
            stalled <= 1'b0;
          end else begin
            r_stall <= w_stall_inc;
            stalled <= (w_stall_inc == STALL_LIM);
          end
          // Dropping enable discards the partial window. A window ending in
          // this same cycle has already been published above.
          if (!enable) begin
            r_state <= S_IDLE;
            r_gate  <= '0;
            r_edge  <= '0;
            r_stall <= '0;
            stalled <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
